// File: rtl/spi_slave_ili9341_rx_pkg.sv
// Shared types and constants for the ILI9341 panel-side SPI receiver.
package pkg_ili9341;

  typedef enum logic {RX_IDLE, RX_SHIFT} spi_rx_state_t;

  localparam logic [7:0] CMD_SWRESET_C = 8'h01;
  localparam logic [7:0] CMD_RAMWR     = 8'h2C;

  typedef struct {
    logic [7:0] data;
    logic       dc;
  } spi_byte_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_slave_ili9341_rx_sync_edge.sv
// Multi-flop synchronizer for one async pin with single-cycle rise/fall pulses
// measured against the previous synchronized value.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_ili9341_rx.sv
// SPI mode-0 slave modelling the ILI9341 receive side; oversamples the link on clk.
// Optional readback on miso is enabled by defining SPI_MISO_EN.
//
// state    | meaning
// RX_IDLE  | cs high (or just reset); sclk edges ignored
// RX_SHIFT | cs low; sclk rises shift mosi in, every 8th bit emits a byte
module spi_slave_ili9341_rx
  import pkg_ili9341::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_SWRESET = CMD_SWRESET_C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       dc,
  input  logic       lcd_reset,
  output logic       miso,
  input  logic [7:0] tx_byte,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic [7:0] last_cmd,
  output logic [7:0] param_cnt,
  output logic       sw_reset,
  output logic       frame_err,
  output logic       busy
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;

  // cs idles high so its synchronizer resets high: no false frame start after rst.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs),
    .q    (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sr, dc_sr, lrst_sr;
  logic                   mosi_s, dc_s, lcd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sr <= '0;
      dc_sr   <= '0;
      lrst_sr <= '0;
    end else begin
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      dc_sr   <= {dc_sr[SYNC_STAGES-2:0], dc};
      lrst_sr <= {lrst_sr[SYNC_STAGES-2:0], lcd_reset};
    end
  end

  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign dc_s   = dc_sr[SYNC_STAGES-1];
  assign lcd_ok = lrst_sr[SYNC_STAGES-1];

  spi_rx_state_t state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          byte_done, err_set, frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= 3'd0;
    end else if (!lcd_ok) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done   = 1'b0;
    err_set     = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (cs_fall) begin
          state_d     = RX_SHIFT;
          bit_cnt_d   = 3'd0;
          frame_start = 1'b1;
        end
      end
      RX_SHIFT: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          byte_done = (bit_cnt_q == 3'd7);
        end
        // A cs rise coinciding with the 8th edge lands on count 0: byte kept, no error.
        if (cs_rise) begin
          state_d = RX_IDLE;
          err_set = (bit_cnt_d != 3'd0);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  logic [6:0] shift_q;
  logic [7:0] byte_w;
  spi_byte_t  rx_q;
  logic       rx_valid_q, sw_reset_q, frame_err_q;
  logic [7:0] last_cmd_q, param_cnt_q;

  assign byte_w = {shift_q, mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= 7'd0;
      rx_q.data   <= 8'd0;
      rx_q.dc     <= 1'b0;
      rx_valid_q  <= 1'b0;
      sw_reset_q  <= 1'b0;
      frame_err_q <= 1'b0;
      last_cmd_q  <= 8'd0;
      param_cnt_q <= 8'd0;
    end else if (!lcd_ok) begin
      shift_q     <= 7'd0;
      rx_q.data   <= 8'd0;
      rx_q.dc     <= 1'b0;
      rx_valid_q  <= 1'b0;
      sw_reset_q  <= 1'b0;
      frame_err_q <= 1'b0;
      last_cmd_q  <= 8'd0;
      param_cnt_q <= 8'd0;
    end else begin
      rx_valid_q <= byte_done;
      sw_reset_q <= byte_done & ~dc_s & (byte_w == CMD_SWRESET);
      if (state_q == RX_SHIFT && sclk_rise) begin
        shift_q <= byte_w[6:0];
      end
      if (byte_done) begin
        rx_q.data <= byte_w;
        rx_q.dc   <= dc_s;
        if (!dc_s) begin
          last_cmd_q  <= byte_w;
          param_cnt_q <= 8'd0;
        end else begin
          param_cnt_q <= sat_inc8(param_cnt_q);
        end
      end
      if (frame_start) begin
        frame_err_q <= 1'b0;
      end else if (err_set) begin
        frame_err_q <= 1'b1;
      end
    end
  end

`ifdef SPI_MISO_EN
  logic [7:0] tx_shift_q;
  logic       tx_hold_q;

  // After a reload on the 8th rise, the following fall must expose the new MSB
  // rather than shift it away, so that one fall is skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_q <= 8'd0;
      tx_hold_q  <= 1'b0;
    end else if (!lcd_ok) begin
      tx_shift_q <= 8'd0;
      tx_hold_q  <= 1'b0;
    end else if (frame_start || byte_done) begin
      tx_shift_q <= tx_byte;
      tx_hold_q  <= byte_done;
    end else if (state_q == RX_SHIFT && sclk_fall) begin
      if (tx_hold_q) begin
        tx_hold_q <= 1'b0;
      end else begin
        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
      end
    end
  end

  assign miso = (state_q == RX_SHIFT) & tx_shift_q[7];
`else
  logic unused_tx;
  assign unused_tx = ^{tx_byte, sclk_fall};
  assign miso      = 1'b0;
`endif

  logic unused_sclk;
  assign unused_sclk = sclk_s;

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_q.data;
  assign rx_dc     = rx_q.dc;
  assign last_cmd  = last_cmd_q;
  assign param_cnt = param_cnt_q;
  assign sw_reset  = sw_reset_q;
  assign frame_err = frame_err_q;
  assign busy      = ~cs_s & lcd_ok;

endmodule
